i2s_tx: RTL and testbench

- Downstream of the reverb stage. Takes the mono mixed sample stream (one sample per sample tick) through a one-entry valid/ready holding register.
- Serialises each sample to an external I2S DAC. Generates BCLK/LRCLK from the system clock and sends the same sample on the left and right slots.
- Flags underrun when no new sample has arrived by frame start.

---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_bclk_gen.sv | 35 +++
 rtl/i2s_tx.sv | 136 +++++++++++++
 tb/tb_i2s_tx.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and sample type used by the reverb stage and the I2S transmitter.
package audio_pkg;

  localparam int DEF_DATA_BITS = 16;
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_CLK_DIV   = 4;

  typedef logic signed [DEF_DATA_BITS-1:0] sample_t;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: BCLK toggles every CLK_DIV system clocks; fall_evt marks the
// clk cycle whose closing edge drives BCLK from 1 to 0.
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic fall_evt
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             term;

  assign term     = (div_cnt == TERM);
  assign fall_evt = term & bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter with a one-entry sample holding register.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (MSB on the LRCLK edge).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_valid,
  input  logic [DATA_BITS-1:0] sample_in,
  output logic                 sample_ready,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int IDX_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);

  logic                 bclk;
  logic                 fall_evt;
  logic [CNT_W-1:0]     bitcnt;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 ready_en;
  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] last;
  slot_e                lrclk_q;
  logic                 sdata_q;

  logic                 wrap;
  logic                 load;
  logic                 take;
  logic [CNT_W-1:0]     nxt_cnt;
  logic [CNT_W-1:0]     nxt_pos;
  slot_e                nxt_slot;
  logic [DATA_BITS-1:0] nxt_word;
  logic [IDX_W-1:0]     bit_idx;
  logic                 nxt_bit;
  int                   pos;

  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  // Handshake: a sample transfers on any clk edge where sample_valid and sample_ready
  // are both high. sample_valid while not ready is dropped, never stalled; a lost
  // sample surfaces as an underrun at the next frame.
  assign sample_ready = ready_en & ~hold_full;
  assign take         = sample_valid & sample_ready;

  assign wrap        = (bitcnt == LAST_BIT);
  assign load        = fall_evt & wrap;
  assign frame_start = load;
  assign underrun    = load & ~hold_full;

  assign i2s_bclk  = bclk;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;

  // Next serial bit is chosen for the slot position the counter is about to enter.
  always_comb begin
    nxt_cnt  = wrap ? '0 : bitcnt + 1'b1;
    nxt_slot = (nxt_cnt >= SLOT_LEN) ? SLOT_RIGHT : SLOT_LEFT;
    nxt_pos  = (nxt_slot == SLOT_RIGHT) ? nxt_cnt - SLOT_LEN : nxt_cnt;
    nxt_word = !wrap ? word : (hold_full ? hold : last);
    pos      = int'(nxt_pos);
    bit_idx  = '0;
    nxt_bit  = 1'b0;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    if (pos < DATA_BITS) begin
      bit_idx = IDX_W'(DATA_BITS - 1 - pos);
      nxt_bit = nxt_word[bit_idx];
    end
`else
    // Position 0 still belongs to the previous slot's word (one-BCLK delay).
    if (pos == 0) begin
      nxt_bit = (SLOT_BITS == DATA_BITS) ? word[0] : 1'b0;
    end else if (pos <= DATA_BITS) begin
      bit_idx = IDX_W'(DATA_BITS - pos);
      nxt_bit = nxt_word[bit_idx];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt  <= '0;
      lrclk_q <= SLOT_LEFT;
      sdata_q <= 1'b0;
      word    <= '0;
      last    <= '0;
    end else if (fall_evt) begin
      bitcnt  <= nxt_cnt;
      lrclk_q <= nxt_slot;
      sdata_q <= nxt_bit;
      if (wrap) begin
        word <= nxt_word;
        if (hold_full) begin
          last <= hold;
        end
      end
    end
  end

  // ready_en keeps sample_ready low through reset and the first clk after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      ready_en  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (take) begin
        hold      <= sample_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at CLK_DIV=2, SLOT_BITS=32, DATA_BITS=16.
`timescale 1ns/1ps
module tb_i2s_tx;

  localparam int DATA_BITS  = 16;
  localparam int SLOT_BITS  = 32;
  localparam int CLK_DIV    = 2;
  localparam int FRAME_CLKS = 2 * SLOT_BITS * 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  logic [63:0] frm_q[$];
  logic [63:0] lr_q[$];
  int          un_q[$];

  i2s_tx #(
    .DATA_BITS (DATA_BITS),
    .SLOT_BITS (SLOT_BITS),
    .CLK_DIV   (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- frame monitor ----------------
  // Samples sdata/lrclk on each BCLK rise after frame_start; bit index = slot position.
  int          mon_pos = -1;
  int          mon_un = 0;
  logic        bclk_q = 1'b0;
  logic [63:0] mon_bits = '0;
  logic [63:0] mon_lr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pos = -1;
      bclk_q  = 1'b0;
    end else begin
      if (frame_start) begin
        mon_pos = 0;
        mon_un  = underrun ? 1 : 0;
      end else if (underrun) begin
        mon_un = mon_un + 1;
      end
      if (i2s_bclk && !bclk_q && mon_pos >= 0) begin
        mon_bits[6'(mon_pos)] = i2s_sdata;
        mon_lr[6'(mon_pos)]   = i2s_lrclk;
        mon_pos = mon_pos + 1;
        if (mon_pos == 64) begin
          frm_q.push_back(mon_bits);
          lr_q.push_back(mon_lr);
          un_q.push_back(mon_un);
          mon_pos = -1;
        end
      end
      bclk_q = i2s_bclk;
    end
  end

  // Reference frame for a word: both slots carry it, MSB at position 1 (I2S) or 0 (LJ).
  function automatic logic [63:0] exp_frame(input logic [15:0] w);
    logic [63:0] f = '0;
    for (int p = 0; p < SLOT_BITS; p++) begin
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      if (p < DATA_BITS) begin
        f[6'(p)]             = w[4'(DATA_BITS - 1 - p)];
        f[6'(p + SLOT_BITS)] = w[4'(DATA_BITS - 1 - p)];
      end
`else
      if (p >= 1 && p <= DATA_BITS) begin
        f[6'(p)]             = w[4'(DATA_BITS - p)];
        f[6'(p + SLOT_BITS)] = w[4'(DATA_BITS - p)];
      end
`endif
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_frames();
    frm_q.delete();
    lr_q.delete();
    un_q.delete();
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_fs: frame_start seen=0 required=1");
    end
  endtask

  task automatic wait_frames(input int n, output bit ok);
    for (int i = 0; i < (n + 1) * FRAME_CLKS && frm_q.size() < n; i++) @(negedge clk);
    ok = (frm_q.size() >= n);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL wait_frames: got=%0d frames required=%0d", frm_q.size(), n);
    end
  endtask

  task automatic send_sample(input logic [15:0] v);
    int i = 0;
    while (!sample_ready && i < 2 * FRAME_CLKS) begin
      @(negedge clk);
      i++;
    end
    sample_valid = 1'b1;
    sample_in    = v;
    @(negedge clk);
    sample_valid = 1'b0;
    tests_run++;
    if (sample_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_after_capture %h: got=%b required=0", v, sample_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int   lr_at = 0;
    int   fs_at = 0;
    logic any_one = 1'b0;
    logic un_at = 1'b0;
    logic rdy1 = 1'b0;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready, frame_start, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got=%b required=000000",
               {i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready, frame_start, underrun});
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) rdy1 = sample_ready;
      if (i2s_sdata) any_one = 1'b1;
      if (i2s_lrclk && lr_at == 0) lr_at = n;
      if (frame_start) begin
        fs_at = n;
        un_at = underrun;
        break;
      end
    end
    tests_run += 5;
    if (rdy1 !== 1'b1) begin
      tests_failed++; $display("FAIL ready_after_release: got=%b required=1", rdy1);
    end
    if (lr_at != 128) begin
      tests_failed++; $display("FAIL first_lrclk_rise: got=%0d required=128", lr_at);
    end
    if (fs_at != 255) begin
      tests_failed++; $display("FAIL first_frame_start: got=%0d required=255", fs_at);
    end
    if (any_one !== 1'b0) begin
      tests_failed++; $display("FAIL first_frame_zero: got=%b required=0", any_one);
    end
    if (un_at !== 1'b1) begin
      tests_failed++; $display("FAIL first_underrun: got=%b required=1", un_at);
    end
    @(negedge clk);
    tests_run++;
    if ({frame_start, underrun} !== 2'b00) begin
      tests_failed++;
      $display("FAIL pulse_width: got=%b required=00", {frame_start, underrun});
    end
  endtask

  task automatic test_clocks();
    int   b1 = -1, b2 = -1, r1 = -1, f1 = -1, r2 = -1;
    logic bq = i2s_bclk;
    logic lq = i2s_lrclk;
    for (int n = 0; n < 3 * FRAME_CLKS && r2 < 0; n++) begin
      @(negedge clk);
      if (i2s_bclk && !bq) begin
        if (b1 < 0) b1 = n;
        else if (b2 < 0) b2 = n;
      end
      if (i2s_lrclk && !lq) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      if (!i2s_lrclk && lq && r1 >= 0 && f1 < 0) f1 = n;
      bq = i2s_bclk;
      lq = i2s_lrclk;
    end
    tests_run += 3;
    if (b2 - b1 != 4) begin
      tests_failed++; $display("FAIL bclk_period: got=%0d required=4", b2 - b1);
    end
    if (r2 - r1 != 256) begin
      tests_failed++; $display("FAIL lrclk_period: got=%0d required=256", r2 - r1);
    end
    if (f1 - r1 != 128) begin
      tests_failed++; $display("FAIL lrclk_high: got=%0d required=128", f1 - r1);
    end
  endtask

  task automatic test_single();
    bit          ok;
    logic [63:0] f;
    logic [15:0] got_l, got_r;
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    int off = 0;
`else
    int off = 1;
`endif
    wait_fs(ok);
    clear_frames();
    send_sample(16'hA5C3);
    wait_frames(2, ok);
    if (ok) begin
      f = frm_q[1];
      for (int i = 0; i < 16; i++) begin
        got_l[4'(15 - i)] = f[6'(i + off)];
        got_r[4'(15 - i)] = f[6'(i + off + SLOT_BITS)];
      end
      tests_run += 5;
      if (got_l !== 16'b1010010111000011) begin
        tests_failed++; $display("FAIL a5c3_left: got=%b required=1010010111000011", got_l);
      end
      if (got_r !== 16'b1010010111000011) begin
        tests_failed++; $display("FAIL a5c3_right: got=%b required=1010010111000011", got_r);
      end
      if (f !== exp_frame(16'hA5C3)) begin
        tests_failed++; $display("FAIL a5c3_frame: got=%h required=%h", f, exp_frame(16'hA5C3));
      end
      if (lr_q[1] !== 64'hFFFFFFFF_00000000) begin
        tests_failed++; $display("FAIL lrclk_map: got=%h required=ffffffff00000000", lr_q[1]);
      end
      if (un_q[1] != 0) begin
        tests_failed++; $display("FAIL a5c3_underrun: got=%0d required=0", un_q[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    logic [15:0] w;
    wait_fs(ok);
    clear_frames();
    send_sample(16'h8001);
    exp_q.push_back(16'h8001);
    wait_fs(ok);
    tests_run += 2;
    if (sample_ready !== 1'b0) begin
      tests_failed++; $display("FAIL ready_at_fs: got=%b required=0", sample_ready);
    end
    if (underrun !== 1'b0) begin
      tests_failed++; $display("FAIL underrun_at_load: got=%b required=0", underrun);
    end
    @(negedge clk);
    tests_run++;
    if (sample_ready !== 1'b1) begin
      tests_failed++; $display("FAIL ready_after_fs: got=%b required=1", sample_ready);
    end
    send_sample(16'h7FFF);
    exp_q.push_back(16'h7FFF);
    wait_frames(3, ok);
    if (ok) begin
      for (int k = 1; k < 3; k++) begin
        w = exp_q.pop_front();
        tests_run += 2;
        if (frm_q[k] !== exp_frame(w)) begin
          tests_failed++; $display("FAIL seq_frame_%h: got=%h required=%h", w, frm_q[k], exp_frame(w));
        end
        if (un_q[k] != 0) begin
          tests_failed++; $display("FAIL seq_underrun_%h: got=%0d required=0", w, un_q[k]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int req_un[4] = '{1, 0, 1, 1};
    logic [15:0] req_w[4] = '{16'h7FFF, 16'h1234, 16'h1234, 16'h1234};
    wait_fs(ok);
    clear_frames();
    send_sample(16'h1234);
    wait_frames(4, ok);
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        tests_run += 2;
        if (frm_q[k] !== exp_frame(req_w[k])) begin
          tests_failed++; $display("FAIL starve_frame%0d: got=%h required=%h", k, frm_q[k], exp_frame(req_w[k]));
        end
        if (un_q[k] != req_un[k]) begin
          tests_failed++; $display("FAIL starve_underrun%0d: got=%0d required=%0d", k, un_q[k], req_un[k]);
        end
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    wait_fs(ok);
    clear_frames();
    send_sample(16'h0F0F);
    sample_valid = 1'b1;
    sample_in    = 16'hFFFF;
    repeat (8) @(negedge clk);
    tests_run++;
    if (sample_ready !== 1'b0) begin
      tests_failed++; $display("FAIL ready_while_full: got=%b required=0", sample_ready);
    end
    sample_valid = 1'b0;
    wait_frames(3, ok);
    if (ok) begin
      tests_run += 3;
      if (frm_q[1] !== exp_frame(16'h0F0F)) begin
        tests_failed++; $display("FAIL drop_frame1: got=%h required=%h", frm_q[1], exp_frame(16'h0F0F));
      end
      if (frm_q[2] !== exp_frame(16'h0F0F)) begin
        tests_failed++; $display("FAIL drop_frame2: got=%h required=%h", frm_q[2], exp_frame(16'h0F0F));
      end
      if (un_q[2] != 1) begin
        tests_failed++; $display("FAIL drop_underrun: got=%0d required=1", un_q[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit   ok;
    bit   found = 1'b0;
    int   lr_at = 0;
    int   fs_at = 0;
    logic any_one = 1'b0;
    logic un_at = 1'b0;
    wait_fs(ok);
    send_sample(16'h5555);
    for (int n = 0; n < FRAME_CLKS; n++) begin
      @(negedge clk);
      if (i2s_lrclk && i2s_sdata && i2s_bclk) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL mid_right_search: found=0 required=1");
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready, frame_start, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got=%b required=000000",
               {i2s_bclk, i2s_lrclk, i2s_sdata, sample_ready, frame_start, underrun});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (i2s_sdata) any_one = 1'b1;
      if (i2s_lrclk && lr_at == 0) lr_at = n;
      if (frame_start) begin
        fs_at = n;
        un_at = underrun;
        break;
      end
    end
    tests_run += 4;
    if (lr_at != 128) begin
      tests_failed++; $display("FAIL restart_lrclk_rise: got=%0d required=128", lr_at);
    end
    if (fs_at != 255) begin
      tests_failed++; $display("FAIL restart_frame_start: got=%0d required=255", fs_at);
    end
    if (any_one !== 1'b0) begin
      tests_failed++; $display("FAIL restart_zero_frame: got=%b required=0", any_one);
    end
    if (un_at !== 1'b1) begin
      tests_failed++; $display("FAIL restart_underrun: got=%b required=1", un_at);
    end
    clear_frames();
    wait_frames(1, ok);
    if (ok) begin
      tests_run += 2;
      if (frm_q[0] !== 64'h0) begin
        tests_failed++; $display("FAIL hold_discarded: got=%h required=0", frm_q[0]);
      end
      if (un_q[0] != 1) begin
        tests_failed++; $display("FAIL hold_discarded_underrun: got=%0d required=1", un_q[0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clocks();
    test_single();
    test_back_to_back();
    test_underrun();
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
